// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and default timing constants for the
//                multiplexed seven-segment display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Scan FSM: dead-time with all anodes off, then one digit lit.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Default timing constants (clk cycles).
  localparam int c_def_cycles_per_digit = 48000;
  localparam int c_def_blank_cycles     = 480;

endpackage : display_pkg
`default_nettype wire

// File: rtl/display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : display_mux
//  Description : Time-multiplexed driver for NUM_DIGITS seven-segment digits.
//                Each digit is lit for CYCLES_PER_DIGIT cycles, separated by
//                BLANK_CYCLES of dead time. A new display value is accepted
//                only in the blank window ahead of digit 0, so every frame
//                shows one coherent value. Optional leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int CYCLES_PER_DIGIT = c_def_cycles_per_digit,
  parameter int BLANK_CYCLES     = c_def_blank_cycles
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  output logic                          load_ready,
  input  logic                          blank_lz,
  output logic [3:0]                    digit_hex,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int c_idx_w   = $clog2(NUM_DIGITS);
  localparam int c_cnt_max = (CYCLES_PER_DIGIT > BLANK_CYCLES) ? CYCLES_PER_DIGIT : BLANK_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(CYCLES_PER_DIGIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NUM_DIGITS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_cnt_w-1:0]      w_cnt_nxt;
  logic [c_idx_w-1:0]      r_idx;
  logic [c_idx_w-1:0]      w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] w_disp_nxt;

  logic                    w_ready;
  logic                    w_suppress;
  logic [3:0]              w_hex;
  logic [NUM_DIGITS-1:0]   w_anode_n;

  // A digit above 0 is a leading zero when it and every digit above it are 0.
  // Digit 0 is always shown so an all-zero value still reads "0".
  function automatic logic lz_suppressed(input logic [4*NUM_DIGITS-1:0] value,
                                         input logic [c_idx_w-1:0]      idx);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(idx)) && (value[4*k +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    return (idx != '0) && upper_zero;
  endfunction

  // Scan state, cycle counter, digit pointer and display register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_disp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_disp  <= w_disp_nxt;
    end
  end

  // Next-state logic: BLANK <-> SHOW with digit advance at the end of SHOW;
  // loads are taken only when the block is ready.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_cnt_w'(1);
    w_idx_nxt   = r_idx;
    w_disp_nxt  = r_disp;

    if (load_valid && w_ready) begin
      w_disp_nxt = load_data;
    end

    case (r_state)
      BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (r_cnt == c_show_last) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == c_idx_last) ? '0 : (r_idx + c_idx_w'(1));
        end
      end
      default: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Ready window is the blank slot ahead of digit 0 (frame boundary).
  always_comb begin
    w_ready    = (r_state == BLANK) && (r_idx == '0);
    w_suppress = blank_lz && lz_suppressed(r_disp, r_idx);
  end

  // Nibble select; valid in BLANK too so the external decoder settles early.
  always_comb begin
    w_hex = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == c_idx_w'(k)) begin
        w_hex = r_disp[4*k +: 4];
      end
    end
  end

  // One-cold anode drive in SHOW only; a suppressed digit keeps all anodes off.
  always_comb begin
    w_anode_n = '1;
    if ((r_state == SHOW) && !w_suppress) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (r_idx == c_idx_w'(k)) begin
          w_anode_n[k] = 1'b0;
        end
      end
    end
  end

  assign load_ready = w_ready;
  assign digit_hex  = w_hex;
  assign anode_n    = w_anode_n;
  assign digit_idx  = r_idx;

endmodule : display_mux
`default_nettype wire

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed seven-segment digits (range 2..8).
REQ-002 SHALL have parameter CYCLES_PER_DIGIT, default 48000, clk cycles each digit is lit (must be >= 1).
REQ-003 SHALL have parameter BLANK_CYCLES, default 480, dead-time cycles between digits with all anodes off (must be >= 1).
REQ-004 clk  input  1  single clock; one clock, all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load_valid  input  1  producer offers a new display value.
REQ-007 load_data  input  4*NUM_DIGITS  display value; nibble k is digit k, digit 0 = bits [3:0].
REQ-008 load_ready  output  1  block accepts load_data this cycle.
REQ-009 blank_lz  input  1  leading-zero suppression enable.
REQ-010 digit_hex  output  4  nibble for the currently selected digit; drives the hex-to-segment decoder.
REQ-011 anode_n  output  NUM_DIGITS  active-low digit enables.
REQ-012 digit_idx  output  $clog2(NUM_DIGITS)  currently selected digit.

Function
REQ-013 FSM states SHALL be BLANK and SHOW; the cycle counter SHALL count 0..BLANK_CYCLES-1 in BLANK and 0..CYCLES_PER_DIGIT-1 in SHOW.
REQ-014 BLANK SHALL go to SHOW on the clk edge where the counter equals BLANK_CYCLES-1; the counter SHALL clear on that edge.
REQ-015 SHOW SHALL go to BLANK on the clk edge where the counter equals CYCLES_PER_DIGIT-1, and digit_idx SHALL increment on that edge, wrapping NUM_DIGITS-1 -> 0.
REQ-016 Frame period SHALL be NUM_DIGITS*(BLANK_CYCLES+CYCLES_PER_DIGIT) cycles.
REQ-017 load_ready SHALL be 1 exactly when state==BLANK and digit_idx==0; it is combinational from registered state.
REQ-018 On an edge with load_valid && load_ready, load_data SHALL be captured into the display register; when load_ready is 0, load_valid SHALL be ignored and load_data is not sampled.
REQ-019 Multiple handshakes in one BLANK window SHALL be allowed; the last one wins. A new value therefore first appears at digit 0 of the next frame, so each frame is coherent.
REQ-020 digit_hex SHALL equal display-register nibble digit_idx in both states, so the decoder settles during BLANK.
REQ-021 anode_n SHALL be all ones in BLANK. In SHOW, only bit digit_idx SHALL be 0, unless that digit is suppressed.
REQ-022 With blank_lz=1, digit k>0 SHALL be suppressed when nibbles k..NUM_DIGITS-1 are all zero. Digit 0 SHALL never be suppressed. blank_lz is sampled combinationally.
REQ-023 At most one anode_n bit SHALL be 0 in any cycle.

Reset
REQ-024 While reset is high, state SHALL be BLANK, counter 0, digit_idx 0, display register 0 and anode_n all ones. Consequently digit_hex is 0 and load_ready is 1.
REQ-025 Reset asserted mid-operation SHALL force REQ-024 values immediately, without waiting for clk. After deassertion, the first frame SHALL begin with a full BLANK_CYCLES window.

Structure
REQ-026 Package display_pkg SHALL hold the state enum (BLANK, SHOW) and the default constants for CYCLES_PER_DIGIT and BLANK_CYCLES.
REQ-027 No sub-module SHALL be required. The leading-zero detect SHALL be an internal combinational function. The seven-segment decoder SHALL be instantiated by the parent, fed by digit_hex.

Verification (NUM_DIGITS=4, CYCLES_PER_DIGIT=4, BLANK_CYCLES=2)
REQ-028 Reset release: anode_n=4'b1111, load_ready=1, digit_idx=0 and digit_hex=0 SHALL hold for 2 cycles; then digit 0 SHALL light with hex 0.
REQ-029 Load 16'h1234 in the first window with blank_lz=0:
- digit_hex SHALL be 4,3,2,1 with anode_n 1110,1101,1011,0111, each for 4 cycles.
- Each digit SHALL be separated by 2 cycles of 1111.
- The frame period SHALL be 24 cycles.
REQ-030 Load 16'h0050 with blank_lz=1: digits 0 and 1 SHALL light (hex 0 and 5), and anode_n SHALL stay 1111 during the SHOW slots of digits 2 and 3. Load 16'h0000 with blank_lz=1: only digit 0 SHALL light. With blank_lz=0, all digits SHALL light.
REQ-031 Hold load_valid=1 with 16'hABCD starting during digit 2 SHOW: the old value SHALL remain displayed and load_ready SHALL stay 0 until the BLANK before digit 0; the load SHALL then be accepted and digit 0 SHALL show hex D.
REQ-032 Loads of 16'h1111 then 16'h2222 on consecutive ready cycles: the next frame SHALL show 2,2,2,2.
REQ-033 Assert reset asynchronously (between clk edges) during digit 2 SHOW: anode_n SHALL go to 1111 and digit_hex to 0 before the next clk edge.
